fir_mac_engine: RTL and testbench

//  Time-multiplexed 33-tap real FIR datapath downstream of the FIR coefficient register block.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_round_sat.sv | 40 ++++
 rtl/fir_mac_engine.sv | 185 ++++++++++++++++++
 tb/tb_fir_mac_engine.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and test-vector source codes for the FIR MAC engine.
package fir_pkg;

  localparam int NTAPS_DEF     = 33;
  localparam int DW_DEF        = 16;
  localparam int CW_DEF        = 16;
  localparam int ACCW_DEF      = 40;
  localparam int OUT_SHIFT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    ROUND = 3'd4,
    OUT   = 3'd5
  } fir_state_e;

  localparam logic [1:0] TV_PASS = 2'd0;
  localparam logic [1:0] TV_IMP  = 2'd1;
  localparam logic [1:0] TV_DC   = 2'd2;
  localparam logic [1:0] TV_RAMP = 2'd3;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of the accumulator to DW bits.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACCW      = ACCW_DEF,
  parameter int DW        = DW_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic signed [ACCW-1:0] acc,
  output logic        [DW-1:0]   data,
  output logic                   sat
);

  localparam logic signed [ACCW-1:0] RND  = {{(ACCW-OUT_SHIFT){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACCW-1:0] rounded_s;
  logic signed [ACCW-1:0] shifted_s;

  assign rounded_s = acc + RND;
  assign shifted_s = rounded_s >>> OUT_SHIFT;

  // clamp the shifted value into the signed DW-bit range and flag clipping
  always_comb begin
    data = shifted_s[DW-1:0];
    sat  = 1'b0;
    if (shifted_s > MAXV) begin
      data = {1'b0, {(DW-1){1'b1}}};
      sat  = 1'b1;
    end else if (shifted_s < MINV) begin
      data = {1'b1, {(DW-1){1'b0}}};
      sat  = 1'b1;
    end else begin
      data = shifted_s[DW-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed single-MAC FIR with rounding/saturation and lossless valid/ready handshakes.
// Optional build macro FIR_TESTVEC_EN selects built-in test-vector sources via testvec_sel[1:0].
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int NTAPS     = NTAPS_DEF,
  parameter int DW        = DW_DEF,
  parameter int CW        = CW_DEF,
  parameter int ACCW      = ACCW_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NTAPS*CW-1:0]   coeff_flat,
  input  logic [15:0]           testvec_sel,
  input  logic [DW-1:0]         s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DW-1:0]         m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic                  sat_clr,
  output logic                  sat_flag,
  output logic                  busy
);

  localparam int IW = $clog2(NTAPS);
  localparam int PW = DW + CW;

  fir_state_e state_r, next_state_s;
  logic [IW-1:0] wp_r, rd_idx_r, tap_r;
  logic drain_r;
  logic signed [DW-1:0] hist_r [NTAPS];
  logic signed [CW-1:0] coef_r [NTAPS];
  logic [DW-1:0] in_r, sample_s;
  logic signed [DW-1:0] op_x_r;
  logic signed [CW-1:0] op_c_r;
  logic op_vld_r, prod_vld_r;
  logic signed [PW-1:0] prod_r;
  logic signed [ACCW-1:0] acc_r;
  logic [DW-1:0] rs_data_s, m_tdata_r;
  logic rs_sat_s, s_tready_r, m_tvalid_r, sat_flag_r, busy_r, accept_s;
  logic unused_sel_s;

  assign accept_s     = s_tvalid & s_tready_r;
  assign unused_sel_s = ^testvec_sel;

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) next_state_s = LOAD; else next_state_s = IDLE;
      LOAD:    next_state_s = MAC;
      MAC:     if (tap_r == IW'(NTAPS-1)) next_state_s = DRAIN; else next_state_s = MAC;
      DRAIN:   if (drain_r) next_state_s = ROUND; else next_state_s = DRAIN;
      ROUND:   next_state_s = OUT;
      OUT:     if (m_tready) next_state_s = IDLE; else next_state_s = OUT;
      default: next_state_s = IDLE;
    endcase
  end

`ifdef FIR_TESTVEC_EN
  logic [1:0]    last_mode_r;
  logic [DW-1:0] ramp_r;

  // history source select; impulse and ramp restart whenever their mode is freshly entered
  always_comb begin
    sample_s = in_r;
    case (testvec_sel[1:0])
      TV_PASS: sample_s = in_r;
      TV_IMP:  if (last_mode_r != TV_IMP) sample_s = {1'b0, {(DW-1){1'b1}}};
               else sample_s = {DW{1'b0}};
      TV_DC:   sample_s = {2'b01, {(DW-2){1'b0}}};
      TV_RAMP: if (last_mode_r != TV_RAMP) sample_s = {DW{1'b0}};
               else sample_s = ramp_r;
      default: sample_s = in_r;
    endcase
  end

  // mode tracking for the test-vector generators, advanced once per loaded sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mode_r <= TV_PASS;
      ramp_r      <= {DW{1'b0}};
    end else if (state_r == LOAD) begin
      last_mode_r <= testvec_sel[1:0];
      if (testvec_sel[1:0] == TV_RAMP) begin
        ramp_r <= (last_mode_r != TV_RAMP) ? {{(DW-1){1'b0}}, 1'b1} : ramp_r + 1'b1;
      end
    end
  end
`else
  assign sample_s = in_r;
`endif

  // FSM state, input capture, write pointer and tap sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      in_r     <= {DW{1'b0}};
      wp_r     <= {IW{1'b0}};
      rd_idx_r <= {IW{1'b0}};
      tap_r    <= {IW{1'b0}};
      drain_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) in_r <= s_tdata;
      if (state_r == LOAD) begin
        wp_r     <= (wp_r == IW'(NTAPS-1)) ? {IW{1'b0}} : wp_r + 1'b1;
        rd_idx_r <= wp_r;
        tap_r    <= {IW{1'b0}};
        drain_r  <= 1'b0;
      end else if (state_r == MAC) begin
        rd_idx_r <= (rd_idx_r == {IW{1'b0}}) ? IW'(NTAPS-1) : rd_idx_r - 1'b1;
        tap_r    <= tap_r + 1'b1;
      end else if (state_r == DRAIN) begin
        drain_r <= 1'b1;
      end
    end
  end

  // sample history and per-sample coefficient snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        hist_r[i] <= {DW{1'b0}};
        coef_r[i] <= {CW{1'b0}};
      end
    end else if (state_r == LOAD) begin
      hist_r[wp_r] <= sample_s;
      for (int i = 0; i < NTAPS; i++) coef_r[i] <= coeff_flat[i*CW +: CW];
    end
  end

  // operand -> product -> accumulate pipeline; DRAIN covers the two register stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_x_r     <= {DW{1'b0}};
      op_c_r     <= {CW{1'b0}};
      op_vld_r   <= 1'b0;
      prod_r     <= {PW{1'b0}};
      prod_vld_r <= 1'b0;
      acc_r      <= {ACCW{1'b0}};
    end else begin
      op_x_r     <= hist_r[rd_idx_r];
      op_c_r     <= coef_r[tap_r];
      op_vld_r   <= (state_r == MAC);
      prod_r     <= PW'(op_x_r) * PW'(op_c_r);
      prod_vld_r <= op_vld_r;
      if (state_r == LOAD) acc_r <= {ACCW{1'b0}};
      else if (prod_vld_r) acc_r <= acc_r + ACCW'(prod_r);
    end
  end

  fir_round_sat #(.ACCW(ACCW), .DW(DW), .OUT_SHIFT(OUT_SHIFT)) u_round_sat (
    .acc  (acc_r),
    .data (rs_data_s),
    .sat  (rs_sat_s)
  );

  // registered handshake/status outputs; a new saturation beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_tready_r <= 1'b0;
      busy_r     <= 1'b0;
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= {DW{1'b0}};
      sat_flag_r <= 1'b0;
    end else begin
      s_tready_r <= (next_state_s == IDLE);
      busy_r     <= (next_state_s != IDLE);
      m_tvalid_r <= (next_state_s == OUT);
      if (state_r == ROUND) m_tdata_r <= rs_data_s;
      if ((state_r == ROUND) && rs_sat_s) sat_flag_r <= 1'b1;
      else if (sat_clr) sat_flag_r <= 1'b0;
    end
  end

  assign s_tready = s_tready_r;
  assign busy     = busy_r;
  assign m_tvalid = m_tvalid_r;
  assign m_tdata  = m_tdata_r;
  assign sat_flag = sat_flag_r;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: directed scenarios plus random stimulus against a queue-based FIR model.
`timescale 1ns/1ps
module tb_fir_mac_engine;
  import fir_pkg::*;

  localparam int NT = 33;

  logic             clk = 1'b0;
  logic             rst;
  logic [NT*16-1:0] coeff_flat;
  logic [15:0]      testvec_sel;
  logic [15:0]      s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [15:0]      m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             sat_clr;
  logic             sat_flag;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int xq[$];          // xq[k] holds x[n-k]
  bit model_sat;

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .clk(clk), .rst(rst), .coeff_flat(coeff_flat), .testvec_sel(testvec_sel),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .sat_clr(sat_clr), .sat_flag(sat_flag), .busy(busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    xq.delete();
    for (int i = 0; i < NT; i++) xq.push_back(0);
  endfunction

  function automatic int coef(input int k);
    logic signed [15:0] c;
    c = coeff_flat[k*16 +: 16];
    return int'(c);
  endfunction

  // y[n] = sat16(round(sum c_k * x[n-k] / 2^15))
  function automatic void model_push(input logic [15:0] x, output logic [15:0] y, output bit s);
    logic signed [15:0] xs;
    longint acc, r;
    xs = x;
    xq.push_front(int'(xs));
    void'(xq.pop_back());
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(xq[k]) * longint'(coef(k));
    r = (acc + 64'sd16384) >>> 15;
    if (r > 64'sd32767) begin y = 16'h7FFF; s = 1'b1; end
    else if (r < -64'sd32768) begin y = 16'h8000; s = 1'b1; end
    else begin y = r[15:0]; s = 1'b0; end
    if (s) model_sat = 1'b1;
  endfunction

  function automatic logic [15:0] exp_impulse(input int i);
    if (i == 15) return 16'd10;
    else if (i == 16) return 16'd29999;
    else if (i == 17) return 16'd10;
    else return 16'd0;
  endfunction

  task automatic set_default_coefs();
    coeff_flat = '0;
    coeff_flat[15*16 +: 16] = 16'd10;
    coeff_flat[16*16 +: 16] = 16'd30000;
    coeff_flat[17*16 +: 16] = 16'd10;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_sat = 1'b0;
    @(negedge clk);
  endtask

  // one sample in, one result out (m_tready held high); optional mid-MAC write of c16=0
  task automatic xfer(input logic [15:0] x, input bit poke, output logic [15:0] y, output bit sat_seen);
    int n;
    y = 16'h0;
    sat_seen = 1'b0;
    @(negedge clk);
    s_tdata  = x;
    s_tvalid = 1'b1;
    n = 0;
    while (s_tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL xfer_ready: s_tready=%b after %0d cycles, required 1", s_tready, n);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tdata  = 16'($urandom);
    if (poke) begin
      repeat (10) @(posedge clk);
      #1 coeff_flat[16*16 +: 16] = 16'h0000;
    end
    n = 0;
    @(negedge clk);
    while (m_tvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL xfer_valid: m_tvalid=%b after %0d cycles, required 1", m_tvalid, n);
      return;
    end
    y = m_tdata;
    sat_seen = sat_flag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_tready, m_tvalid, busy, sat_flag} !== 4'b0000 || m_tdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/busy/sat=%b%b%b%b data=%h, required 0000 data=0000",
               s_tready, m_tvalid, busy, sat_flag, m_tdata);
    end
    rst = 1'b0;
    model_reset();
    model_sat = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_ready_first: got %b required 0", s_tready); end
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ready_after: rdy=%b busy=%b required rdy=1 busy=0", s_tready, busy);
    end
  endtask

  task automatic test_impulse();
    logic [15:0] y, e, m;
    bit s, ms;
    set_default_coefs();
    for (int i = 0; i < 40; i++) begin
      model_push((i == 0) ? 16'h7FFF : 16'h0000, m, ms);
      xfer((i == 0) ? 16'h7FFF : 16'h0000, 1'b0, y, s);
      e = exp_impulse(i);
      checks++;
      if (y !== e) begin errors++; $display("FAIL impulse out%0d: got %h required %h", i, y, e); end
    end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL impulse_sat: got %b required 0", sat_flag); end
  endtask

  task automatic test_saturation();
    logic [15:0] y, e;
    bit s, es;
    for (int k = 0; k < NT; k++) coeff_flat[k*16 +: 16] = 16'h7FFF;
    for (int i = 0; i < 40; i++) begin
      model_push(16'h7FFF, e, es);
      xfer(16'h7FFF, 1'b0, y, s);
      checks++;
      if (y !== e) begin errors++; $display("FAIL sat_pos out%0d: got %h required %h", i, y, e); end
    end
    checks++;
    if (y !== 16'h7FFF || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_pos_final: data=%h flag=%b required 7fff/1", y, sat_flag);
    end
    @(negedge clk) sat_clr = 1'b1;
    @(negedge clk) sat_clr = 1'b0;
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clr: got %b required 0", sat_flag); end
    for (int i = 0; i < 35; i++) begin
      model_push(16'h8000, e, es);
      xfer(16'h8000, 1'b0, y, s);
      checks++;
      if (y !== e) begin errors++; $display("FAIL sat_neg out%0d: got %h required %h", i, y, e); end
    end
    checks++;
    if (y !== 16'h8000) begin errors++; $display("FAIL sat_neg_final: got %h required 8000", y); end
    // clear held high while a new saturation lands: the set must win
    sat_clr = 1'b1;
    model_push(16'h8000, e, es);
    xfer(16'h8000, 1'b0, y, s);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL sat_set_wins: flag=%b required 1", s); end
    @(negedge clk);
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clr_after: got %b required 0", sat_flag); end
    sat_clr = 1'b0;
    model_sat = 1'b0;
  endtask

  task automatic test_latency_backpressure();
    logic [15:0] e, held;
    bit es;
    int n, cyc, ready_bad, stable_bad;
    set_default_coefs();
    model_push(16'h1000, e, es);
    m_tready = 1'b0;
    @(negedge clk);
    s_tdata = 16'h1000;
    s_tvalid = 1'b1;
    n = 0;
    while (s_tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 s_tvalid = 1'b0;
    cyc = 0;
    ready_bad = 0;
    while (cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (m_tvalid === 1'b1) break;
      if (s_tready !== 1'b0) ready_bad++;
    end
    checks++;
    if (cyc !== 37) begin errors++; $display("FAIL latency: m_tvalid at cycle %0d required 37", cyc); end
    checks++;
    if (m_tdata !== e) begin errors++; $display("FAIL bp_data: got %h required %h", m_tdata, e); end
    held = m_tdata;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== held || s_tready !== 1'b0 || busy !== 1'b1) stable_bad++;
    end
    checks++;
    if (ready_bad !== 0 || stable_bad !== 0) begin
      errors++; $display("FAIL bp_hold: ready_bad=%0d stable_bad=%0d required 0/0", ready_bad, stable_bad);
    end
    m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b busy=%b required 0/1/0", m_tvalid, s_tready, busy);
    end
  endtask

  task automatic test_coeff_snapshot();
    logic [15:0] y, e;
    bit s, es;
    set_default_coefs();
    for (int i = 0; i < 17; i++) begin
      model_push(16'h4000, e, es);
      xfer(16'h4000, 1'b0, y, s);
      checks++;
      if (y !== e) begin errors++; $display("FAIL snap_pre%0d: got %h required %h", i, y, e); end
    end
    model_push(16'h4000, e, es);
    xfer(16'h4000, 1'b1, y, s);
    checks++;
    if (y !== 16'd15010) begin errors++; $display("FAIL snap_n: got %0d required 15010", y); end
    model_push(16'h4000, e, es);
    xfer(16'h4000, 1'b0, y, s);
    checks++;
    if (y !== 16'd10) begin errors++; $display("FAIL snap_n1: got %0d required 10", y); end
  endtask

  task automatic test_reset_mid_mac();
    int n, spurious;
    set_default_coefs();
    @(negedge clk);
    s_tdata = 16'h7FFF;
    s_tvalid = 1'b1;
    n = 0;
    while (s_tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 s_tvalid = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: vld=%b busy=%b required 0/0", m_tvalid, busy);
    end
    @(negedge clk) rst = 1'b0;
    model_reset();
    model_sat = 1'b0;
    spurious = 0;
    repeat (50) begin @(negedge clk); if (m_tvalid !== 1'b0) spurious++; end
    checks++;
    if (spurious !== 0) begin errors++; $display("FAIL mid_reset_emit: %0d valid cycles required 0", spurious); end
    test_impulse();
  endtask

  task automatic test_random();
    logic [15:0] y, e, x;
    logic signed [15:0] c;
    bit s, es;
    @(negedge clk) sat_clr = 1'b1;
    @(negedge clk) sat_clr = 1'b0;
    model_sat = 1'b0;
    for (int k = 0; k < NT; k++) begin
      c = 16'($urandom);
      coeff_flat[k*16 +: 16] = 16'(c >>> $urandom_range(2, 8));
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        c = 16'($urandom);
        coeff_flat[$urandom_range(0, NT-1)*16 +: 16] = 16'(c >>> $urandom_range(0, 8));
      end
`ifndef FIR_TESTVEC_EN
      testvec_sel = 16'($urandom);
`endif
      x = 16'($urandom);
      model_push(x, e, es);
      xfer(x, 1'b0, y, s);
      checks++;
      if (y !== e) begin errors++; $display("FAIL random%0d: x=%h got %h required %h", i, x, y, e); end
    end
    checks++;
    if (sat_flag !== model_sat) begin errors++; $display("FAIL random_sat: got %b required %b", sat_flag, model_sat); end
    testvec_sel = 16'h0;
  endtask

`ifdef FIR_TESTVEC_EN
  task automatic test_testvec();
    logic [15:0] y, e;
    bit s, es;
    apply_reset();
    set_default_coefs();
    testvec_sel = {14'h0, TV_IMP};
    for (int i = 0; i < 40; i++) begin
      model_push((i == 0) ? 16'h7FFF : 16'h0000, e, es);
      xfer(16'h1234, 1'b0, y, s);
      e = exp_impulse(i);
      checks++;
      if (y !== e) begin errors++; $display("FAIL tv_impulse out%0d: got %h required %h", i, y, e); end
    end
    coeff_flat[0*16 +: 16] = 16'h7FFF;
    testvec_sel = {14'h0, TV_RAMP};
    for (int i = 0; i < 10; i++) begin
      model_push(16'(i), e, es);
      xfer(16'h1234, 1'b0, y, s);
      checks++;
      if (y !== e) begin errors++; $display("FAIL tv_ramp%0d: got %h required %h", i, y, e); end
    end
    testvec_sel = {14'h0, TV_DC};
    for (int i = 0; i < 3; i++) begin
      model_push(16'h4000, e, es);
      xfer(16'h1234, 1'b0, y, s);
      checks++;
      if (y !== e) begin errors++; $display("FAIL tv_dc%0d: got %h required %h", i, y, e); end
    end
    testvec_sel = 16'h0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    coeff_flat = '0;
    testvec_sel = 16'h0;
    s_tdata = 16'h0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    sat_clr = 1'b0;
    model_sat = 1'b0;
    model_reset();
    test_reset();
    test_impulse();
    test_saturation();
    test_latency_backpressure();
    test_coeff_snapshot();
    test_reset_mid_mac();
    test_random();
`ifdef FIR_TESTVEC_EN
    test_testvec();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
